// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32 control FSM with memory wait timeout and sticky trap
module multicycle_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  state_t st, nxt;
  logic [6:0] op_q;
  logic [CW-1:0] cnt;
  logic [1:0] cause_nxt;
  logic timeout, legal, is_alu, is_ld, is_st, is_br, is_jal, is_jalr;
  assign state   = st;
  assign timeout = !mem_ready && cnt == CW'(WAIT_MAX);
  assign legal   = opcode inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
  assign is_alu  = op_q == OP_R || op_q == OP_I;
  assign is_ld   = op_q == OP_LD;
  assign is_st   = op_q == OP_ST;
  assign is_br   = op_q == OP_BR;
  assign is_jal  = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  // strobes and next state decoded from the current state; everything is held low during reset
  always_comb begin
    {ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, rf_we, wb_sel} = '0;
    nxt = st;
    cause_nxt = trap_cause;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ir_we = mem_ready;
        nxt = mem_ready ? DECODE : timeout ? TRAP : FETCH;
        cause_nxt = timeout ? 2'd2 : trap_cause;
      end
      DECODE: begin
        nxt = legal ? EXEC : TRAP;
        cause_nxt = legal ? trap_cause : 2'd1;
      end
      EXEC: begin
        pc_we = is_br | is_jal | is_jalr;
        pc_sel = is_jalr ? 2'd2 : (is_jal | (is_br & branch_taken)) ? 2'd1 : 2'd0;
        rf_we = is_jal | is_jalr;
        wb_sel = (is_jal | is_jalr) ? 2'd2 : 2'd0;
        nxt = is_alu ? WB : (is_ld | is_st) ? MEM : FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        addr_sel = 1'b1;
        mem_we = is_st;
        pc_we = mem_ready & is_st;
        nxt = mem_ready ? (is_st ? FETCH : WB) : timeout ? TRAP : MEM;
        cause_nxt = timeout ? 2'd2 : trap_cause;
      end
      WB: begin
        rf_we = 1'b1;
        wb_sel = is_ld ? 2'd1 : 2'd0;
        pc_we = 1'b1;
        nxt = FETCH;
      end
      TRAP: nxt = TRAP;
      default: begin
        nxt = TRAP;
        cause_nxt = 2'd1;
      end
    endcase
    if (!rst_n) {ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, rf_we, wb_sel} = '0;
  end
  // state, wait counter, latched opcode, trap flag and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= FETCH;
      trap <= 1'b0;
      trap_cause <= 2'd0;
      instret <= '0;
      cnt <= '0;
      op_q <= '0;
    end else begin
      st <= nxt;
      trap <= nxt == TRAP;
      trap_cause <= cause_nxt;
      instret <= instret + {31'd0, pc_we};
      cnt <= (mem_req && !mem_ready && !timeout) ? cnt + CW'(1) : '0;
      op_q <= st == DECODE ? opcode : op_q;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction phase model checked cycle by cycle against the controller
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic [6:0] opcode = '0;
  logic ir_we, pc_we, mem_req, mem_we, addr_sel, rf_we, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [2:0] state;
  logic [31:0] instret;
  logic [9:0] strobes;
  logic [31:0] exp_instret = '0;
  int checks = 0, passed = 0;
  logic [6:0] ops [7] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};

  multicycle_ctrl #(.WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;
  assign strobes = {ir_we, pc_we, pc_sel, mem_req, mem_we, addr_sel, rf_we, wb_sel};

  function automatic logic [9:0] sv(input logic ir, input logic pw, input logic [1:0] ps,
                                    input logic mr, input logic mw, input logic as,
                                    input logic rw, input logic [1:0] ws);
    return {ir, pw, ps, mr, mw, as, rw, ws};
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [6:0] op, input logic br,
                     input int est, input logic [9:0] es);
    mem_ready = rdy;
    opcode = op;
    branch_taken = br;
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(est));
    chk({tag, ".strobes"}, 32'(strobes), 32'(es));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = r7();
    @(negedge clk);
    chk({tag, ".rst_strobes"}, 32'(strobes), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_instret = '0;
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".trap"}, 32'(trap), 32'd0);
    chk({tag, ".cause"}, 32'(trap_cause), 32'd0);
    chk({tag, ".instret"}, instret, 32'd0);
  endtask

  task automatic do_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                          input logic br);
    logic st;
    st = op == OP_ST;
    for (int i = 0; i < fw; i++) cyc({tag, ".fwait"}, 1'b0, r7(), r1(), 0, sv(0, 0, 0, 1, 0, 0, 0, 0));
    cyc({tag, ".fetch"}, 1'b1, r7(), r1(), 0, sv(1, 0, 0, 1, 0, 0, 0, 0));
    cyc({tag, ".decode"}, r1(), op, r1(), 1, '0);
    case (op)
      OP_R, OP_I: begin
        cyc({tag, ".exec"}, r1(), r7(), r1(), 2, '0);
        cyc({tag, ".wb"}, r1(), r7(), r1(), 4, sv(0, 1, 0, 0, 0, 0, 1, 0));
      end
      OP_LD, OP_ST: begin
        cyc({tag, ".exec"}, r1(), r7(), r1(), 2, '0);
        for (int i = 0; i < mw; i++) cyc({tag, ".mwait"}, 1'b0, r7(), r1(), 3, sv(0, 0, 0, 1, st, 1, 0, 0));
        cyc({tag, ".mem"}, 1'b1, r7(), r1(), 3, sv(0, st, 0, 1, st, 1, 0, 0));
        if (!st) cyc({tag, ".wb"}, r1(), r7(), r1(), 4, sv(0, 1, 0, 0, 0, 0, 1, 1));
      end
      OP_BR: cyc({tag, ".exec"}, r1(), r7(), br, 2, sv(0, 1, {1'b0, br}, 0, 0, 0, 0, 0));
      OP_JAL: cyc({tag, ".exec"}, r1(), r7(), r1(), 2, sv(0, 1, 1, 0, 0, 0, 1, 2));
      default: cyc({tag, ".exec"}, r1(), r7(), r1(), 2, sv(0, 1, 2, 0, 0, 0, 1, 2));
    endcase
    exp_instret++;
    chk({tag, ".instret"}, instret, exp_instret);
  endtask

  initial begin
    #1;
    do_reset("init");
    do_instr("add", OP_R, 0, 0, 1'b0);
    do_instr("lw", OP_LD, 0, 3, 1'b0);
    do_instr("beq_t", OP_BR, 0, 0, 1'b1);
    do_instr("beq_n", OP_BR, 0, 0, 1'b0);
    do_instr("jal", OP_JAL, 2, 0, 1'b0);
    do_instr("jalr", OP_JALR, 1, 0, 1'b0);
    do_instr("sw", OP_ST, 0, 2, 1'b0);
    do_instr("addi", OP_I, 3, 0, 1'b0);
    do_instr("fetch16", OP_R, 16, 0, 1'b0);
    do_instr("mem16", OP_LD, 0, 16, 1'b0);
    do_instr("st16", OP_ST, 16, 16, 1'b0);
    for (int n = 0; n < 40; n++) begin
      int k, fw, mw;
      k = $urandom_range(0, 6);
      fw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 5);
      mw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 5);
      do_instr("rnd", ops[k], fw, mw, r1());
    end
    cyc("ill.fetch", 1'b1, r7(), r1(), 0, sv(1, 0, 0, 1, 0, 0, 0, 0));
    cyc("ill.decode", r1(), 7'b0110111, r1(), 1, '0);
    for (int i = 0; i < 20; i++) cyc("ill.trap", r1(), r7(), r1(), 5, '0);
    chk("ill.trap_flag", 32'(trap), 32'd1);
    chk("ill.cause", 32'(trap_cause), 32'd1);
    chk("ill.instret", instret, exp_instret);
    do_reset("rst_after_ill");
    for (int i = 0; i < 17; i++) cyc("to.fetch", 1'b0, r7(), r1(), 0, sv(0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) cyc("to.trap", r1(), r7(), r1(), 5, '0);
    chk("to.trap_flag", 32'(trap), 32'd1);
    chk("to.cause", 32'(trap_cause), 32'd2);
    chk("to.instret", instret, 32'd0);
    do_reset("rst_after_to");
    do_instr("pre_st", OP_R, 0, 0, 1'b0);
    cyc("rs.fetch", 1'b1, r7(), r1(), 0, sv(1, 0, 0, 1, 0, 0, 0, 0));
    cyc("rs.decode", r1(), OP_ST, r1(), 1, '0);
    cyc("rs.exec", r1(), r7(), r1(), 2, '0);
    cyc("rs.mwait", 1'b0, r7(), r1(), 3, sv(0, 0, 0, 1, 1, 1, 0, 0));
    rst_n = 1'b0;
    cyc("rs.in_reset", 1'b1, r7(), r1(), 3, '0);
    rst_n = 1'b1;
    chk("rs.state", 32'(state), 32'd0);
    chk("rs.instret", instret, 32'd0);
    cyc("rs.refetch", 1'b0, r7(), r1(), 0, sv(0, 0, 0, 1, 0, 0, 0, 0));
    exp_instret = '0;
    do_instr("post_rst", OP_LD, 0, 1, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
